// File: rtl/reservation_station_if.sv
// Issue, CDB and functional-unit signal bundle for the reservation station.
// The station uses the slave view; the environment driving it uses master.
interface reservation_station_if #(
  parameter int DEPTH  = 4,
  parameter int TAG_W  = 8,
  parameter int DATA_W = 16
);
  localparam int OCC_W = $clog2(DEPTH + 1);

  logic              issue_valid;
  logic              issue_ready;
  logic [DATA_W-1:0] issue_instr;
  logic [TAG_W-1:0]  issue_num;
  logic [DATA_W-1:0] issue_vj;
  logic              issue_qj_valid;
  logic [TAG_W-1:0]  issue_qj;
  logic [DATA_W-1:0] issue_vk;
  logic              issue_qk_valid;
  logic [TAG_W-1:0]  issue_qk;
  logic              cdb_valid;
  logic [TAG_W-1:0]  cdb_num;
  logic [DATA_W-1:0] cdb_data;
  logic              uf_available;
  logic              uf_instr_en;
  logic [DATA_W-1:0] uf_instr;
  logic [TAG_W-1:0]  uf_instr_num;
  logic [DATA_W-1:0] uf_r1;
  logic [DATA_W-1:0] uf_r2;
  logic [OCC_W-1:0]  occupancy;

  modport slave (
    input  issue_valid, issue_instr, issue_num, issue_vj, issue_qj_valid, issue_qj,
           issue_vk, issue_qk_valid, issue_qk, cdb_valid, cdb_num, cdb_data, uf_available,
    output issue_ready, uf_instr_en, uf_instr, uf_instr_num, uf_r1, uf_r2, occupancy
  );

  modport master (
    output issue_valid, issue_instr, issue_num, issue_vj, issue_qj_valid, issue_qj,
           issue_vk, issue_qk_valid, issue_qk, cdb_valid, cdb_num, cdb_data, uf_available,
    input  issue_ready, uf_instr_en, uf_instr, uf_instr_num, uf_r1, uf_r2, occupancy
  );
endinterface

// File: rtl/reservation_station.sv
// Tomasulo reservation station: buffers issued instructions, snoops the CDB for
// missing operands and dispatches one ready entry at a time to the functional unit.
module reservation_station #(
  parameter int DEPTH  = 4,
  parameter int TAG_W  = 8,
  parameter int DATA_W = 16
) (
  input logic                  clock,
  input logic                  reset_n,
  reservation_station_if.slave rs
);
  localparam int IDX_W = $clog2(DEPTH);
  localparam int OCC_W = $clog2(DEPTH + 1);

  logic [DEPTH-1:0]  busy_q, busy_d, qjv_q, qjv_d, qkv_q, qkv_d;
  logic [DATA_W-1:0] instr_q [DEPTH];
  logic [DATA_W-1:0] instr_d [DEPTH];
  logic [DATA_W-1:0] vj_q    [DEPTH];
  logic [DATA_W-1:0] vj_d    [DEPTH];
  logic [DATA_W-1:0] vk_q    [DEPTH];
  logic [DATA_W-1:0] vk_d    [DEPTH];
  logic [TAG_W-1:0]  num_q   [DEPTH];
  logic [TAG_W-1:0]  num_d   [DEPTH];
  logic [TAG_W-1:0]  qj_q    [DEPTH];
  logic [TAG_W-1:0]  qj_d    [DEPTH];
  logic [TAG_W-1:0]  qk_q    [DEPTH];
  logic [TAG_W-1:0]  qk_d    [DEPTH];

  logic              holdoff_q, holdoff_d, uf_en_q, uf_en_d;
  logic [DATA_W-1:0] uf_instr_q, uf_instr_d, uf_r1_q, uf_r1_d, uf_r2_q, uf_r2_d;
  logic [TAG_W-1:0]  uf_num_q, uf_num_d;
  logic [OCC_W-1:0]  occ_q, occ_d;

  logic [DEPTH-1:0]  ready;
  logic [IDX_W-1:0]  free_idx, disp_idx;
  logic              issue_ready, do_issue, do_disp, is_mem, hit_j, hit_k;

  // Lowest-index free slot and lowest-index ready slot, both from registered state.
  always_comb begin
    ready    = busy_q & ~qjv_q & ~qkv_q;
    free_idx = '0;
    disp_idx = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (!busy_q[i]) free_idx = IDX_W'(i);
      if (ready[i])   disp_idx = IDX_W'(i);
    end
  end

  assign issue_ready = ~&busy_q;
  assign do_issue    = rs.issue_valid && issue_ready;
  assign do_disp     = !holdoff_q && rs.uf_available && |ready;
  assign is_mem      = (rs.issue_instr[DATA_W-1 -: 4] == 4'd2) ||
                       (rs.issue_instr[DATA_W-1 -: 4] == 4'd3);
  assign hit_j       = rs.cdb_valid && rs.issue_qj_valid && (rs.issue_qj == rs.cdb_num);
  assign hit_k       = rs.cdb_valid && rs.issue_qk_valid && !is_mem && (rs.issue_qk == rs.cdb_num);

  always_comb begin
    busy_d  = busy_q;
    qjv_d   = qjv_q;
    qkv_d   = qkv_q;
    instr_d = instr_q;
    num_d   = num_q;
    vj_d    = vj_q;
    vk_d    = vk_q;
    qj_d    = qj_q;
    qk_d    = qk_q;
    for (int i = 0; i < DEPTH; i++) begin
      if (busy_q[i] && rs.cdb_valid) begin
        if (qjv_q[i] && (qj_q[i] == rs.cdb_num)) begin
          vj_d[i]  = rs.cdb_data;
          qjv_d[i] = 1'b0;
        end
        if (qkv_q[i] && (qk_q[i] == rs.cdb_num)) begin
          vk_d[i]  = rs.cdb_data;
          qkv_d[i] = 1'b0;
        end
      end
      if (do_disp && (disp_idx == IDX_W'(i))) busy_d[i] = 1'b0;
      // The free slot is never the dispatched one, so issue cannot collide with dispatch.
      if (do_issue && (free_idx == IDX_W'(i))) begin
        busy_d[i]  = 1'b1;
        instr_d[i] = rs.issue_instr;
        num_d[i]   = rs.issue_num;
        qj_d[i]    = rs.issue_qj;
        qk_d[i]    = rs.issue_qk;
        vj_d[i]    = hit_j ? rs.cdb_data : rs.issue_vj;
        vk_d[i]    = hit_k ? rs.cdb_data : rs.issue_vk;
        qjv_d[i]   = rs.issue_qj_valid && !hit_j;
        qkv_d[i]   = rs.issue_qk_valid && !is_mem && !hit_k;
      end
    end
  end

  always_comb begin
    uf_en_d    = do_disp;
    holdoff_d  = do_disp;
    uf_instr_d = uf_instr_q;
    uf_num_d   = uf_num_q;
    uf_r1_d    = uf_r1_q;
    uf_r2_d    = uf_r2_q;
    if (do_disp) begin
      uf_instr_d = instr_q[disp_idx];
      uf_num_d   = num_q[disp_idx];
      uf_r1_d    = vk_q[disp_idx];
      uf_r2_d    = vj_q[disp_idx];
    end
    occ_d = occ_q + OCC_W'(do_issue) - OCC_W'(do_disp);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      busy_q     <= '0;
      qjv_q      <= '0;
      qkv_q      <= '0;
      holdoff_q  <= 1'b0;
      uf_en_q    <= 1'b0;
      uf_instr_q <= '0;
      uf_num_q   <= '0;
      uf_r1_q    <= '0;
      uf_r2_q    <= '0;
      occ_q      <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        instr_q[i] <= '0;
        num_q[i]   <= '0;
        vj_q[i]    <= '0;
        vk_q[i]    <= '0;
        qj_q[i]    <= '0;
        qk_q[i]    <= '0;
      end
    end else begin
      busy_q     <= busy_d;
      qjv_q      <= qjv_d;
      qkv_q      <= qkv_d;
      holdoff_q  <= holdoff_d;
      uf_en_q    <= uf_en_d;
      uf_instr_q <= uf_instr_d;
      uf_num_q   <= uf_num_d;
      uf_r1_q    <= uf_r1_d;
      uf_r2_q    <= uf_r2_d;
      occ_q      <= occ_d;
      instr_q    <= instr_d;
      num_q      <= num_d;
      vj_q       <= vj_d;
      vk_q       <= vk_d;
      qj_q       <= qj_d;
      qk_q       <= qk_d;
    end
  end

  assign rs.issue_ready  = issue_ready;
  assign rs.uf_instr_en  = uf_en_q;
  assign rs.uf_instr     = uf_instr_q;
  assign rs.uf_instr_num = uf_num_q;
  assign rs.uf_r1        = uf_r1_q;
  assign rs.uf_r2        = uf_r2_q;
  assign rs.occupancy    = occ_q;
endmodule

// File: tb/tb_reservation_station.sv
// Bench for reservation_station: directed issue/CDB/FU scenarios with a dispatch
// scoreboard filled as stimulus is driven and drained on every uf_instr_en pulse.
module tb_reservation_station;
  typedef struct {
    logic [15:0] instr;
    logic [7:0]  num;
    logic [15:0] r1;
    logic [15:0] r2;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   total = 0;
  int   bad = 0;
  logic prev_en = 1'b0;
  exp_t sb[$];
  exp_t mon_e;

  reservation_station_if #(.DEPTH(4), .TAG_W(8), .DATA_W(16)) bus ();
  reservation_station #(.DEPTH(4), .TAG_W(8), .DATA_W(16)) dut (
    .clock(clk), .reset_n(rst_n), .rs(bus)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic push(input logic [15:0] instr, input logic [7:0] num,
                      input logic [15:0] r1, input logic [15:0] r2);
    exp_t e;
    e.instr = instr; e.num = num; e.r1 = r1; e.r2 = r2;
    sb.push_back(e);
  endtask

  task automatic issue(input logic [15:0] instr, input logic [7:0] num,
                       input logic [15:0] vj, input logic qjv, input logic [7:0] qj,
                       input logic [15:0] vk, input logic qkv, input logic [7:0] qk);
    bus.issue_instr = instr; bus.issue_num = num;
    bus.issue_vj = vj; bus.issue_qj_valid = qjv; bus.issue_qj = qj;
    bus.issue_vk = vk; bus.issue_qk_valid = qkv; bus.issue_qk = qk;
    bus.issue_valid = 1'b1;
    @(negedge clk);
    bus.issue_valid = 1'b0;
  endtask

  task automatic cdb(input logic [7:0] tag, input logic [15:0] data);
    bus.cdb_valid = 1'b1; bus.cdb_num = tag; bus.cdb_data = data;
    @(negedge clk);
    bus.cdb_valid = 1'b0;
  endtask

  task automatic wait_en(input int budget, input string tag);
    for (int n = 0; n < budget; n++) begin
      @(negedge clk);
      if (bus.uf_instr_en) break;
    end
    chk(tag, bus.uf_instr_en, 1'b1);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Scoreboard: each dispatch pulse must match the oldest pending expectation.
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.uf_instr_en) begin
        chk("no_b2b_pulse", prev_en, 1'b0);
        chk("sb_has_entry", sb.size() != 0, 1'b1);
        if (sb.size() != 0) begin
          mon_e = sb.pop_front();
          chk("disp_instr", bus.uf_instr, mon_e.instr);
          chk("disp_num", bus.uf_instr_num, mon_e.num);
          chk("disp_r1", bus.uf_r1, mon_e.r1);
          chk("disp_r2", bus.uf_r2, mon_e.r2);
        end
      end
      prev_en <= bus.uf_instr_en;
    end else begin
      prev_en <= 1'b0;
    end
  end

  initial begin
    bus.issue_valid = 0; bus.issue_instr = 0; bus.issue_num = 0;
    bus.issue_vj = 0; bus.issue_qj_valid = 0; bus.issue_qj = 0;
    bus.issue_vk = 0; bus.issue_qk_valid = 0; bus.issue_qk = 0;
    bus.cdb_valid = 0; bus.cdb_num = 0; bus.cdb_data = 0; bus.uf_available = 0;
    idle(2);
    chk("rst_en", bus.uf_instr_en, 1'b0);
    chk("rst_occ", bus.occupancy, 0);
    chk("rst_ready", bus.issue_ready, 1'b1);
    chk("rst_instr", bus.uf_instr, 0);
    chk("rst_num", bus.uf_instr_num, 0);
    chk("rst_r1", bus.uf_r1, 0);
    chk("rst_r2", bus.uf_r2, 0);
    rst_n = 1'b1;
    bus.uf_available = 1'b1;

    // Ready ADD dispatches one edge after issue.
    push(16'h0123, 8'd1, 16'd3, 16'd5);
    issue(16'h0123, 8'd1, 16'd5, 0, 0, 16'd3, 0, 0);
    chk("t1_occ1", bus.occupancy, 1);
    chk("t1_en0", bus.uf_instr_en, 1'b0);
    @(negedge clk);
    chk("t1_en1", bus.uf_instr_en, 1'b1);
    chk("t1_occ0", bus.occupancy, 0);
    @(negedge clk);
    chk("t1_pulse_end", bus.uf_instr_en, 1'b0);
    chk("t1_hold_r2", bus.uf_r2, 16'd5);

    // SUB waits for its j operand from the CDB.
    issue(16'h1234, 8'd2, 16'hdead, 1, 8'd9, 16'd4, 0, 0);
    chk("t2_occ1", bus.occupancy, 1);
    repeat (3) begin
      @(negedge clk);
      chk("t2_no_early", bus.uf_instr_en, 1'b0);
    end
    push(16'h1234, 8'd2, 16'd4, 16'd20);
    cdb(8'd9, 16'd20);
    chk("t2_capture_edge", bus.uf_instr_en, 1'b0);
    @(negedge clk);
    chk("t2_dispatch", bus.uf_instr_en, 1'b1);
    idle(2);

    // Issue and matching CDB at the same edge: bypass.
    push(16'h0456, 8'd3, 16'd2, 16'd11);
    bus.cdb_valid = 1; bus.cdb_num = 8'd7; bus.cdb_data = 16'd11;
    issue(16'h0456, 8'd3, 16'hbeef, 1, 8'd7, 16'd2, 0, 0);
    bus.cdb_valid = 0;
    @(negedge clk);
    chk("t3_bypass_disp", bus.uf_instr_en, 1'b1);
    idle(2);

    // Fill, overflow issue ignored, resolve entry 2 first.
    bus.uf_available = 0;
    for (int i = 0; i < 4; i++)
      issue(16'h0010 + 16'(i), 8'(10 + i), 16'h0, 1, 8'(20 + i), 16'h0100 + 16'(i), 0, 0);
    chk("t4_full_ready", bus.issue_ready, 1'b0);
    chk("t4_occ4", bus.occupancy, 4);
    issue(16'h0999, 8'd14, 16'd1, 0, 0, 16'd1, 0, 0);
    chk("t4_ignored_occ", bus.occupancy, 4);
    chk("t4_ignored_ready", bus.issue_ready, 1'b0);
    bus.uf_available = 1;
    push(16'h0012, 8'd12, 16'h0102, 16'd100);
    cdb(8'd22, 16'd100);
    chk("t4_still_full", bus.issue_ready, 1'b0);
    chk("t4_capture_edge", bus.uf_instr_en, 1'b0);
    @(negedge clk);
    chk("t4_e2_disp", bus.uf_instr_en, 1'b1);
    chk("t4_ready_back", bus.issue_ready, 1'b1);
    chk("t4_occ3", bus.occupancy, 3);
    for (int i = 0; i < 4; i++) begin
      if (i != 2) begin
        push(16'h0010 + 16'(i), 8'(10 + i), 16'h0100 + 16'(i), 16'h0200 + 16'(i));
        cdb(8'(20 + i), 16'h0200 + 16'(i));
        wait_en(4, "t4_drain");
      end
    end
    idle(2);
    chk("t4_empty", bus.occupancy, 0);

    // FU busy for a multi-cycle ADD holds off the second dispatch.
    bus.uf_available = 0;
    push(16'h0501, 8'd30, 16'h0022, 16'h0011);
    push(16'h0502, 8'd31, 16'h0044, 16'h0033);
    issue(16'h0501, 8'd30, 16'h0011, 0, 0, 16'h0022, 0, 0);
    issue(16'h0502, 8'd31, 16'h0033, 0, 0, 16'h0044, 0, 0);
    bus.uf_available = 1;
    wait_en(4, "t5_first");
    bus.uf_available = 0;
    repeat (3) begin
      @(negedge clk);
      chk("t5_fu_busy", bus.uf_instr_en, 1'b0);
    end
    bus.uf_available = 1;
    @(negedge clk);
    chk("t5_second", bus.uf_instr_en, 1'b1);
    idle(2);

    // Two LDs with FU always available: pulses every other cycle; k tag ignored.
    push(16'h3050, 8'd40, 16'h0077, 16'h0066);
    push(16'h3060, 8'd41, 16'h0088, 16'h0099);
    issue(16'h3050, 8'd40, 16'h0066, 0, 0, 16'h0077, 1, 8'd5);
    chk("t5_ld_issue_edge", bus.uf_instr_en, 1'b0);
    issue(16'h3060, 8'd41, 16'h0099, 0, 0, 16'h0088, 1, 8'd6);
    chk("t5_ld_p1", bus.uf_instr_en, 1'b1);
    @(negedge clk);
    chk("t5_ld_gap", bus.uf_instr_en, 1'b0);
    @(negedge clk);
    chk("t5_ld_p2", bus.uf_instr_en, 1'b1);
    idle(2);

    // Reset while entries are busy and a dispatch pulse is high.
    bus.uf_available = 0;
    for (int i = 0; i < 3; i++)
      issue(16'h0700 + 16'(i), 8'(70 + i), 16'h0, 1, 8'(50 + i), 16'h1, 0, 0);
    push(16'h0600, 8'd60, 16'd2, 16'd1);
    issue(16'h0600, 8'd60, 16'd1, 0, 0, 16'd2, 0, 0);
    bus.uf_available = 1;
    wait_en(4, "t6_pulse");
    chk("t6_occ3", bus.occupancy, 3);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_rst_en", bus.uf_instr_en, 1'b0);
    chk("t6_rst_occ", bus.occupancy, 0);
    chk("t6_rst_ready", bus.issue_ready, 1'b1);
    chk("t6_rst_instr", bus.uf_instr, 0);
    chk("t6_rst_num", bus.uf_instr_num, 0);
    chk("t6_rst_r1", bus.uf_r1, 0);
    chk("t6_rst_r2", bus.uf_r2, 0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cdb(8'(50 + i), 16'h0055);
      chk("t6_dropped", bus.uf_instr_en, 1'b0);
    end
    repeat (3) begin
      @(negedge clk);
      chk("t6_quiet", bus.uf_instr_en, 1'b0);
    end
    push(16'h0800, 8'd80, 16'd4, 16'd3);
    issue(16'h0800, 8'd80, 16'd3, 0, 0, 16'd4, 0, 0);
    wait_en(3, "t6_after_rst");
    idle(3);
    chk("sb_drained", sb.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/reservation_station.md
Name: reservation_station

Overview:
- Tomasulo reservation station sitting directly upstream of the functional unit.
- Buffers issued instructions until both source operands are available.
- Captures missing operands from the common data bus (CDB), driven by the FU's done/instrNum/result.
- Dispatches one ready instruction at a time into the FU using the FU's available/enable handshake.

Parameters:
DEPTH, 4, number of entries (2..8)
TAG_W, 8, instruction-number/tag width
DATA_W, 16, operand and instruction width

Ports:
clock  in  1  rising-edge clock
reset_n  in  1  asynchronous active-low reset
issue_valid  in  1  issue request
issue_ready  out  1  at least one free entry
issue_instr  in  DATA_W  instruction: [15:12] opcode (0 ADD, 1 SUB, 2 SD, 3 LD), [7:4] offset
issue_num  in  TAG_W  instruction number; also used as its result tag
issue_vj  in  DATA_W  source j value (valid when issue_qj_valid=0)
issue_qj_valid  in  1  source j pending
issue_qj  in  TAG_W  tag producing source j
issue_vk  in  DATA_W  source k value
issue_qk_valid  in  1  source k pending
issue_qk  in  TAG_W  tag producing source k
cdb_valid  in  1  broadcast strobe (FU done)
cdb_num  in  TAG_W  broadcast tag
cdb_data  in  DATA_W  broadcast value
uf_available  in  1  FU idle
uf_instr_en  out  1  dispatch strobe
uf_instr  out  DATA_W  dispatched instruction
uf_instr_num  out  TAG_W  dispatched instruction number
uf_r1  out  DATA_W  = Vk
uf_r2  out  DATA_W  = Vj (ADD: Vj+Vk; SUB: Vj−Vk; LD/SD: offset+Vj)
occupancy  out  $clog2(DEPTH+1)  busy-entry count

Behaviour:
- Reset (async, reset_n=0): all entries not busy.
  - uf_instr_en=0; uf_instr, uf_instr_num, uf_r1, uf_r2 = 0; occupancy=0; holdoff=0.
  - Mid-operation reset drops all entries. The FU is not notified.
- Entry state: busy, instr, num, Vj, Qj, Qj_valid, Vk, Qk, Qk_valid.
- Ready: busy && !Qj_valid && !Qk_valid.
- issue_ready is combinational: !(all entries busy), computed from registered state.
  - An entry freed by dispatch in cycle t is not reusable until t+1.
- Issue (issue_valid && issue_ready at edge): write to the lowest-index free entry.
  - Opcodes 2/3: Qk_valid forced 0 (k unused).
  - issue_valid while full is ignored; no entry is written.
- CDB capture (cdb_valid at edge): every busy entry with Qj_valid && Qj==cdb_num loads Vj=cdb_data and clears Qj_valid. Same for k.
  - Bypass: an instruction issued at the same edge whose issue_q* matches cdb_num captures cdb_data immediately and is written as ready.
- Dispatch is evaluated at each edge on registered state, when !holdoff && uf_available && some entry is ready.
  - Select the lowest-index ready entry.
  - Register uf_instr/uf_instr_num/uf_r1/uf_r2 from it and set uf_instr_en=1.
  - Free the entry and set holdoff=1.
- Next edge: uf_instr_en=0, holdoff=0. No dispatch evaluation occurs on that edge, which lets the FU's uf_available drop for multi-cycle ops.
- uf_instr_en is therefore a one-cycle pulse with at least one idle cycle between pulses.
- uf_instr/uf_instr_num/uf_r1/uf_r2 hold their values until the next dispatch. The FU re-reads instr opcode every cycle.
- An entry made ready by CDB at edge t is dispatchable no earlier than edge t+1.
- Simultaneous issue, CDB and dispatch in one cycle are all legal and independent.
- occupancy = previous count + issue − dispatch.
- No opcode checking. Unknown opcodes are dispatched as-is.

Test Plan:
- Reset, then issue ADD num=1, Vj=5, Vk=3, both ready, uf_available=1 -> uf_instr_en pulses 1 cycle later with uf_r2=5, uf_r1=3, uf_instr_num=1; occupancy 1→0.
- Issue SUB num=2, Qj=9 pending, Vk=4; then cdb_valid num=9 data=20 -> no dispatch before the CDB edge; dispatch 1 cycle after capture with uf_r2=20, uf_r1=4.
- Issue with Qj=7 at the same edge as cdb num=7 data=11 -> entry written ready with Vj=11; dispatched next eligible edge.
- Fill 4 entries with pending operands -> issue_ready=0 and a 5th issue is ignored (occupancy stays 4). One CDB resolves entry 2 -> entry 2 dispatches; issue_ready returns the cycle after.
- Two ready ADDs with FU mimicking a 3-cycle ADD -> second pulse only after uf_available returns high; never back-to-back pulses. Two ready LDs with uf_available held 1 -> pulses every 2 cycles.
- Assert reset_n=0 with 3 busy entries and uf_instr_en=1 -> all outputs 0 immediately and occupancy=0; no dispatch after release until new issue.
